// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Purpose  : 4x4 matrix keypad scanner. Drives one active-low column at a
//            time (0111, 1011, 1101, 1110), samples the active-low rows at the
//            end of each column dwell, classifies every full scan as NONE,
//            SINGLE(code) or MULTI, and debounces presses and releases over
//            DEBOUNCE_SCANS consecutive scans.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            col_n[3:0] - column drive, one-hot low
//            row_n[3:0] - row sense, active low, already synchronised
//            key_code   - last accepted key, code = 4*row_idx + col_idx
//            key_valid  - one-clk strobe when a key is accepted
//            key_held   - high while the accepted key is considered pressed
// Options  : KEYPAD_REPEAT_EN - when defined, a held key re-strobes key_valid
//            every REPEAT_SCANS matching full scans.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam bit PARAMS_OK = (SCAN_DIV >= 2) && (DEBOUNCE_SCANS >= 1) && (REPEAT_SCANS >= 1);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned      REP_W    = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS + 1) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    R_NONE   = 2'd0,
    R_SINGLE = 2'd1,
    R_MULTI  = 2'd2
  } scan_res_e;

  // Registered state
  logic [DIV_W-1:0] div_q,       div_d;
  logic [1:0]       col_q,       col_d;
  logic [3:0]       col_n_q,     col_n_d;
  logic             any_q,       any_d;
  logic             multi_q,     multi_d;
  logic [3:0]       acc_code_q,  acc_code_d;
  state_e           state_q,     state_d;
  logic [3:0]       cand_q,      cand_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]       key_code_q,  key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q,  key_held_d;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0] rep_q,       rep_d;
`endif

  // Combinational scan classification
  logic [3:0] rows;
  logic       tick;
  logic       scan_end;
  logic       col_hit;
  logic       col_multi;
  logic [1:0] row_idx;
  logic       res_multi;
  logic       res_any;
  logic [3:0] res_code;
  scan_res_e  scan_res;

  always_comb begin
    rows      = ~row_n;
    tick      = (div_q == DIV_LAST);
    scan_end  = tick && (col_q == 2'd3);
    col_hit   = |rows;
    // More than one bit set: clearing the lowest set bit leaves something.
    col_multi = ((rows & (rows - 4'd1)) != 4'd0);

    // row_n[3] is row 0, row_n[0] is row 3.
    if (rows[3])      row_idx = 2'd0;
    else if (rows[2]) row_idx = 2'd1;
    else if (rows[1]) row_idx = 2'd2;
    else              row_idx = 2'd3;

    // Result of the scan so far, including the column being sampled now.
    // A hit in a second column is MULTI even if each column is clean.
    res_multi = multi_q | col_multi | (any_q & col_hit);
    res_any   = any_q | col_hit;
    res_code  = col_hit ? {row_idx, col_q} : acc_code_q;

    if (res_multi)    scan_res = R_MULTI;
    else if (res_any) scan_res = R_SINGLE;
    else              scan_res = R_NONE;
  end

  // Next-state logic
  always_comb begin
    div_d       = div_q;
    col_d       = col_q;
    col_n_d     = col_n_q;
    any_d       = any_q;
    multi_d     = multi_q;
    acc_code_d  = acc_code_q;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif

    // Column rotation and per-scan accumulation
    if (tick) begin
      div_d   = '0;
      col_d   = col_q + 2'd1;
      col_n_d = ~(4'b1000 >> col_d);
      if (scan_end) begin
        any_d      = 1'b0;
        multi_d    = 1'b0;
        acc_code_d = 4'd0;
      end else begin
        any_d      = res_any;
        multi_d    = res_multi;
        acc_code_d = res_code;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Debounce FSM advances only once per full scan
    if (scan_end) begin
      case (state_q)
        S_IDLE: begin
          if (scan_res == R_SINGLE) begin
            cand_d = res_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_d     = S_PRESSED;
              key_code_d  = res_code;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d       = '0;
`endif
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = CNT_ONE;
            end
          end
        end

        S_DEBOUNCE: begin
          if (scan_res == R_SINGLE && res_code == cand_q) begin
            if (cnt_q >= CNT_LAST) begin
              state_d     = S_PRESSED;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = '0;
`ifdef KEYPAD_REPEAT_EN
              rep_d       = '0;
`endif
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (scan_res == R_SINGLE) begin
            cand_d = res_code;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end

        S_PRESSED: begin
          if (scan_res == R_NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d    = S_IDLE;
              key_held_d = 1'b0;
              cnt_d      = '0;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = CNT_ONE;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
          end
`ifdef KEYPAD_REPEAT_EN
          else if (scan_res == R_SINGLE && res_code == key_code_q) begin
            if (rep_q >= REP_LAST) begin
              key_valid_d = 1'b1;
              rep_d       = '0;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end else begin
            rep_d = '0;
          end
`endif
        end

        S_RELEASE: begin
          if (scan_res == R_NONE) begin
            if (cnt_q >= CNT_LAST) begin
              state_d    = S_IDLE;
              key_held_d = 1'b0;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            // Key came back before release was confirmed: no new strobe.
            state_d = S_PRESSED;
            cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d   = '0;
`endif
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      col_q       <= 2'd0;
      col_n_q     <= 4'b0111;
      any_q       <= 1'b0;
      multi_q     <= 1'b0;
      acc_code_q  <= 4'd0;
      state_q     <= S_IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      any_q       <= any_d;
      multi_q     <= multi_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  // With illegal parameters the scanner parks with every column released.
  assign col_n     = PARAMS_OK ? col_n_q : 4'hF;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan
// Purpose  : Directed self-checking bench for keypad_scan with SCAN_DIV=4,
//            DEBOUNCE_SCANS=3, REPEAT_SCANS=5. A full scan is 16 clks; key
//            changes are applied on scan boundaries measured from reset
//            release. A small keypad model converts the pressed-key mask and
//            the column drive into row levels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys  = 16'h0000;

  int cyc         = 0;
  int base        = 0;
  int n_strobe    = 0;
  int strobe_base = 0;
  int last_cyc    = -1;
  int n_assert    = 0;
  int n_fail      = 0;

`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  keypad_scan #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_SCANS  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: key 4*r+c pulls row_n[3-r] low while col_n[3-c] is low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_n[3-c]) row_n[3-r] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && key_valid) begin
      n_strobe = n_strobe + 1;
      last_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the negedge that follows posedge k (k counted from reset release).
  task automatic wait_to(input int k);
    int guard;
    guard = 0;
    while ((cyc - base) < k) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        n_fail++;
        $display("FAIL wait_to: observed timeout expected cycle %0d", k);
        $fatal(1, "wait bound expired");
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    keys  = 16'h0000;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    base        = cyc;
    strobe_base = n_strobe;
    #1;
  endtask

  initial begin
    // ---- reset values and column rotation ----
    #1 rst_n = 1'b0;
    #1;
    check("rst_col_n", 32'(col_n), 32'(4'b0111));
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    do_reset();
    wait_to(3);
    check("col_dwell_c0", 32'(col_n), 32'(4'b0111));
    wait_to(4);
    check("col_step_c1", 32'(col_n), 32'(4'b1011));
    wait_to(9);
    check("col_step_c2", 32'(col_n), 32'(4'b1101));
    rst_n = 1'b0;
    #1;
    check("midscan_rst_col_n", 32'(col_n), 32'(4'b0111));

    // ---- clean press of code 10 (row 2, column 2) ----
    do_reset();
    keys[10] = 1'b1;
    wait_to(47);
    check("press10_pre_valid", 32'(key_valid), 32'd0);
    wait_to(48);
    check("press10_valid", 32'(key_valid), 32'd1);
    check("press10_code", 32'(key_code), 32'd10);
    check("press10_held", 32'(key_held), 32'd1);
    wait_to(49);
    check("press10_valid_drop", 32'(key_valid), 32'd0);

    // ---- release 2 scans, touch another key, then full release ----
    wait_to(64);
    keys = 16'h0000;
    wait_to(96);
    check("rel_partial_held", 32'(key_held), 32'd1);
    keys[3] = 1'b1;
    wait_to(112);
    keys = 16'h0000;
    check("retouch_strobes", 32'(n_strobe - strobe_base), 32'd1);
    check("retouch_code", 32'(key_code), 32'd10);
    check("retouch_held", 32'(key_held), 32'd1);
    wait_to(159);
    check("rel_full_pre_held", 32'(key_held), 32'd1);
    wait_to(160);
    check("rel_full_held", 32'(key_held), 32'd0);
    check("rel_code_kept", 32'(key_code), 32'd10);

    // ---- bounce: code 5 for 2 scans, gap 1 scan, then 3 scans ----
    do_reset();
    keys[5] = 1'b1;
    wait_to(32);
    keys = 16'h0000;
    wait_to(48);
    keys[5] = 1'b1;
    wait_to(95);
    check("bounce_no_early", 32'(n_strobe - strobe_base), 32'd0);
    wait_to(96);
    check("bounce_valid", 32'(key_valid), 32'd1);
    check("bounce_code", 32'(key_code), 32'd5);
    wait_to(112);
    keys = 16'h0000;
    check("bounce_strobes", 32'(n_strobe - strobe_base), 32'd1);

    // ---- multi-key: codes 0 and 15 together for 10 scans ----
    wait_to(160);
    check("bounce_released", 32'(key_held), 32'd0);
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    wait_to(320);
    check("multi_strobes", 32'(n_strobe - strobe_base), 32'd1);
    check("multi_code_kept", 32'(key_code), 32'd5);
    check("multi_held", 32'(key_held), 32'd0);
    keys[15] = 1'b0;
    wait_to(367);
    check("multi_rel_pre", 32'(key_valid), 32'd0);
    wait_to(368);
    check("multi_rel_valid", 32'(key_valid), 32'd1);
    check("multi_rel_code", 32'(key_code), 32'd0);
    wait_to(369);
    check("multi_rel_strobes", 32'(n_strobe - strobe_base), 32'd2);

    // ---- held key: auto-repeat only with KEYPAD_REPEAT_EN ----
    do_reset();
    keys[7] = 1'b1;
    wait_to(48);
    check("hold7_valid", 32'(key_valid), 32'd1);
    check("hold7_code", 32'(key_code), 32'd7);
    wait_to(128);
    check("hold7_repeat1", 32'(key_valid), REP ? 32'd1 : 32'd0);
    wait_to(369);
    check("hold7_strobes", 32'(n_strobe - strobe_base), REP ? 32'd5 : 32'd1);
    check("hold7_last", 32'(last_cyc - base), REP ? 32'd368 : 32'd48);
    check("hold7_held", 32'(key_held), 32'd1);

    // ---- reset while the strobe is high cancels it ----
    do_reset();
    keys[10] = 1'b1;
    wait_to(48);
    check("cancel_pre_valid", 32'(key_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("cancel_valid", 32'(key_valid), 32'd0);
    check("cancel_held", 32'(key_held), 32'd0);
    check("cancel_code", 32'(key_code), 32'd0);
    check("cancel_col_n", 32'(col_n), 32'(4'b0111));
    keys = 16'h0000;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
